ps2_kbd_port: RTL

- 68000 bus peripheral that consumes the 11-bit event word from the PS/2 keyboard decoder and buffers scan-code events in a FIFO.
- The CPU reads buffered events through a small register window and can be interrupted while events are pending.
- Sits between the ps2 keyboard decoder and the fx68k data bus and IPL inputs. It supplies the per-access DTACK handshake for its own address window.

---
 rtl/ps2_kbd_port.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_port.sv
// ---------------------------------------------------------------------------
// ps2_kbd_port
//
// 68000 bus peripheral that buffers PS/2 keyboard events in a FIFO and
// exposes them to the CPU through a two-register window with an optional
// level interrupt.
//
// Ports:
//   clk      - system (CPU) clock
//   reset_n  - asynchronous active-low reset
//   ps2_key  - decoder event word: [10] toggle, [9] pressed, [8] extended,
//              [7:0] scan code
//   cs       - address window select from the top-level decoder
//   as_n     - CPU address strobe (active low)
//   rw       - 1 = read, 0 = write
//   uds_n    - upper data strobe (ignored)
//   lds_n    - lower data strobe, qualifies writes to the control register
//   addr     - CPU address bits [2:1], register select
//   din      - CPU write data
//   dout     - registered read data, held until the next access
//   dtack_n  - data acknowledge (active low)
//   ipl_n    - interrupt priority request (active low)
//   irq      - level interrupt pending
//
// Register map (word offsets):
//   0 read : DATA   {valid, pressed, extended, 5'b0, code[7:0]} (pops)
//   1 read : STATUS {irq_en, overflow, 9'b0, count[4:0]}
//   1 write: bit0 irq_en, bit1 clear overflow, bit2 flush (needs lds_n = 0)
//   2/3    : read as zero, writes ignored
// ---------------------------------------------------------------------------
module ps2_kbd_port #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [2:0]  IPL_LEVEL  = 3'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        cs,
    input  logic        as_n,
    input  logic        rw,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        dtack_n,
    output logic [2:0]  ipl_n,
    output logic        irq
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   ZERO_CNT = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] ZERO_PTR = {DEPTH_LOG2{1'b0}};

    // State registers and their next-state values
    logic [9:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;
    logic                  irq_en_q,   irq_en_d;
    logic                  armed_q,    armed_d;
    logic                  prev_tog_q, prev_tog_d;
    logic                  start_seen_q, start_seen_d;
    logic [15:0]           dout_q,    dout_d;
    logic                  dtack_n_q, dtack_n_d;
    logic                  irq_q,     irq_d;
    logic [2:0]            ipl_n_q,   ipl_n_d;

    // Decoded strobes
    logic                  access_start_s;
    logic                  push_req_s;
    logic                  push_ok_s;
    logic                  pop_s;
    logic                  flush_s;
    logic                  ctrl_wr_s;
    logic                  full_s;
    logic                  empty_s;
    logic [9:0]            head_s;
    logic [31:0]           count_ext_s;
    logic [4:0]            count5_s;
    logic                  unused_bits_s;

    assign unused_bits_s = ^{uds_n, din[15:3]};

    assign dout    = dout_q;
    assign dtack_n = dtack_n_q;
    assign irq     = irq_q;
    assign ipl_n   = ipl_n_q;

    // Next-state logic for capture, bus decode, FIFO bookkeeping and outputs
    always_comb begin
        access_start_s = cs && !as_n && !start_seen_q;
        full_s         = (count_q == FULL_CNT);
        empty_s        = (count_q == ZERO_CNT);
        head_s         = mem_q[rd_ptr_q];
        count_ext_s    = 32'(count_q);
        count5_s       = count_ext_s[4:0];

        // The first cycle after reset only samples the toggle so that a level
        // already present at release is not mistaken for a new event.
        push_req_s = armed_q && (ps2_key[10] != prev_tog_q);
        ctrl_wr_s  = access_start_s && !rw && (addr == 2'd1) && !lds_n;
        flush_s    = ctrl_wr_s && din[2];
        pop_s      = access_start_s && rw && (addr == 2'd0) && !empty_s;
        push_ok_s  = push_req_s && !full_s && !flush_s;

        armed_d      = 1'b1;
        prev_tog_d   = prev_tog_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        irq_en_d     = irq_en_q;
        start_seen_d = start_seen_q;
        dout_d       = dout_q;
        dtack_n_d    = 1'b1;

        if (!armed_q) begin
            prev_tog_d = ps2_key[10];
        end else if (push_req_s) begin
            prev_tog_d = ps2_key[10];
        end else begin
            prev_tog_d = prev_tog_q;
        end

        // Flush discards everything including a same-cycle event, so it
        // overrides both the push and any pointer movement.
        if (flush_s) begin
            wr_ptr_d = ZERO_PTR;
            rd_ptr_d = ZERO_PTR;
            count_d  = ZERO_CNT;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + ONE_PTR;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ONE_PTR;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
        end

        // A dropped event wins over a same-cycle clear so no loss goes unseen.
        if (push_req_s && full_s && !flush_s) begin
            overflow_d = 1'b1;
        end else if (ctrl_wr_s && din[1]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (ctrl_wr_s) begin
            irq_en_d = din[0];
        end else begin
            irq_en_d = irq_en_q;
        end

        if (as_n) begin
            start_seen_d = 1'b0;
        end else if (access_start_s) begin
            start_seen_d = 1'b1;
        end else begin
            start_seen_d = start_seen_q;
        end

        if (access_start_s && rw) begin
            case (addr)
                2'd0: begin
                    if (empty_s) begin
                        dout_d = 16'h0000;
                    end else begin
                        dout_d = {1'b1, head_s[9], head_s[8], 5'b00000, head_s[7:0]};
                    end
                end
                2'd1:    dout_d = {irq_en_q, overflow_q, 9'b000000000, count5_s};
                default: dout_d = 16'h0000;
            endcase
        end else begin
            dout_d = dout_q;
        end

        // DTACK holds only while the same access is still selected; dropping
        // cs releases it and it cannot re-assert until a new access starts.
        if (access_start_s) begin
            dtack_n_d = 1'b0;
        end else if (!dtack_n_q && cs && !as_n) begin
            dtack_n_d = 1'b0;
        end else begin
            dtack_n_d = 1'b1;
        end

        irq_d = irq_en_q && !empty_s;
        if (irq_d) begin
            ipl_n_d = ~IPL_LEVEL;
        end else begin
            ipl_n_d = 3'b111;
        end
    end

    // Control, pointer and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= ZERO_PTR;
            rd_ptr_q     <= ZERO_PTR;
            count_q      <= ZERO_CNT;
            overflow_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            armed_q      <= 1'b0;
            prev_tog_q   <= 1'b0;
            start_seen_q <= 1'b0;
            dout_q       <= 16'h0000;
            dtack_n_q    <= 1'b1;
            irq_q        <= 1'b0;
            ipl_n_q      <= 3'b111;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            irq_en_q     <= irq_en_d;
            armed_q      <= armed_d;
            prev_tog_q   <= prev_tog_d;
            start_seen_q <= start_seen_d;
            dout_q       <= dout_d;
            dtack_n_q    <= dtack_n_d;
            irq_q        <= irq_d;
            ipl_n_q      <= ipl_n_d;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= ps2_key[9:0];
        end
    end

endmodule
